// File: rtl/pipe_slice.sv
// pipe_slice: fully registered valid/ready pipeline slice (two-entry skid
// buffer). Every output comes straight from a flop, so neither the ready
// path nor the valid/data path has a combinational route through the slice.
// Sustains one word per clock, strict FIFO order, no loss or duplication.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset (takes priority over clr)
//   clr        synchronous flush; empties the slice, data registers untouched
//   in_valid   upstream word offered
//   in_ready   slice can accept (registered)
//   in_data    upstream word
//   out_valid  downstream word offered (registered)
//   out_ready  downstream accepts
//   out_data   downstream word (registered, main register)
//   count      words held, 0..2 (registered)
module pipe_slice #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  // Encoding equals the number of words held, so count is the next state.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]   state_p0;
  logic [1:0]   state_nx;
  logic [N-1:0] main_p0;
  logic [N-1:0] skid_p0;
  logic         accept;
  logic         send;
  logic         ld_main_in;
  logic         ld_main_skid;
  logic         ld_skid;

  // ---- handshake decode and next-state logic ----
  always_comb begin
    accept       = in_valid & in_ready;
    send         = out_valid & out_ready;
    state_nx     = state_p0;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_p0)
      ST_EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_nx   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && send) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid  = 1'b1;
          state_nx = ST_FULL;
        end else if (send) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (send) begin
          ld_main_skid = 1'b1;
          state_nx     = ST_BUSY;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
    // A flush drops everything held plus any word accepted this cycle;
    // the data registers simply keep their old contents.
    if (clr) begin
      state_nx     = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // ---- control registers: outputs are precomputed from the next state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      count     <= 2'd0;
    end else begin
      state_p0  <= state_nx;
      out_valid <= (state_nx != ST_EMPTY);
      in_ready  <= (state_nx != ST_FULL);
      count     <= state_nx;
    end
  end

  // ---- data registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      main_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      if (ld_main_in) begin
        main_p0 <= in_data;
      end else if (ld_main_skid) begin
        main_p0 <= skid_p0;
      end
      if (ld_skid) begin
        skid_p0 <= in_data;
      end
    end
  end

  assign out_data = main_p0;

endmodule

// File: tb/tb_pipe_slice.sv
module tb_pipe_slice;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  count;

  pipe_slice #(.N(32)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  int          ntests = 0;
  int          nfail  = 0;
  int          nsent  = 0;
  logic        acc;
  logic        snd;
  logic        was_rst;
  logic [31:0] q[$];

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        cl;
    logic [1:0]  cnt;
    logic        ov;
    logic        ir;
    logic [31:0] od;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: scoreboard the handshakes on the falling edge (inputs and
  // registered outputs are stable), then check outputs just after the edge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    acc = in_valid & in_ready;
    snd = out_valid & out_ready;
    if (!rst && snd) begin
      if (q.size() == 0) begin
        check("unexpected word", out_data, 32'hdead_beef);
      end else begin
        e = q.pop_front();
        check("sb data", out_data, e);
        nsent++;
      end
    end
    if (rst || clr) q.delete();
    else if (acc) q.push_back(in_data);
    was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) begin
      check("rst in_ready", {31'd0, in_ready}, 32'd0);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst count", {30'd0, count}, 32'd0);
      check("rst out_data", out_data, 32'd0);
    end else begin
      check("model count", {30'd0, count}, q.size());
      check("model out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      check("model in_ready", {31'd0, in_ready}, {31'd0, q.size() != 2});
      if (q.size() != 0) check("model head", out_data, q[0]);
    end
  endtask

  initial begin
    int nacc;
    int cyc;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset, then in_ready rises one edge after release
    repeat (3) step();
    rst = 1'b0;
    step();
    check("in_ready after rst", {31'd0, in_ready}, 32'd1);

    // Full-rate stream: each word visible one cycle after its accept
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i;
      step();
      check("stream data", out_data, i);
      check("stream count", {30'd0, count}, 32'd1);
      check("stream valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step();

    // Backpressure and flush sequences, with explicit expectations
    tbl[0]  = '{1'b1, 32'hA,  1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'hA};
    tbl[1]  = '{1'b1, 32'hB,  1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'hA};
    tbl[2]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'hB};
    tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'hB};
    tbl[4]  = '{1'b1, 32'h11, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h11};
    tbl[5]  = '{1'b1, 32'h22, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h11};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 32'h11};
    tbl[7]  = '{1'b1, 32'h33, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h33};
    tbl[8]  = '{1'b1, 32'h44, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h44};
    tbl[9]  = '{1'b1, 32'h55, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 32'h44};
    tbl[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h44};
    for (int i = 0; i < 11; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d;
      out_ready = tbl[i].ordy; clr = tbl[i].cl;
      step();
      check("tbl count", {30'd0, count}, {30'd0, tbl[i].cnt});
      check("tbl out_valid", {31'd0, out_valid}, {31'd0, tbl[i].ov});
      check("tbl in_ready", {31'd0, in_ready}, {31'd0, tbl[i].ir});
      check("tbl out_data", out_data, tbl[i].od);
    end
    clr = 1'b0;

    // Random traffic; in_valid is held until accepted
    nsent = 0; nacc = 0; cyc = 0;
    in_valid = 1'b0;
    acc = 1'b0;
    while (nsent < 1000 && cyc < 20000) begin
      if (!(in_valid && !acc))
        in_valid = (nacc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 32'h1000 + nacc;
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (acc) nacc++;
      cyc++;
    end
    check("random words delivered", nsent, 1000);
    in_valid = 1'b0; out_ready = 1'b0;
    step();

    // rst and clr together while BUSY
    in_valid = 1'b1; in_data = 32'h77;
    step();
    check("busy before rst", {30'd0, count}, 32'd1);
    in_valid = 1'b0; rst = 1'b1; clr = 1'b1;
    step();
    rst = 1'b0; clr = 1'b0;
    step();

    // rst while FULL: held words vanish, nothing stale appears later
    in_valid = 1'b1; in_data = 32'h81;
    step();
    in_data = 32'h82;
    step();
    check("full before rst", {30'd0, count}, 32'd2);
    in_valid = 1'b0; rst = 1'b1;
    step();
    check("rst full out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      step();
      check("no stale word", {31'd0, out_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_slice.md
# pipe_slice

Fully registered valid/ready pipeline slice (two-entry skid buffer) that cuts every combinational path between an upstream producer and a downstream consumer, including the ready path. The producer side is a ready-gated sink and the consumer side is a valid-driven source. The block is the receiving and re-sending end of the standard valid/ready handshake used between core pipeline stages and bus bridges. It sustains one word per clock with no bubbles and never drops or duplicates a word.

## Interface
Parameters:
- N, 32, data width in bits (N ≥ 1)

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  reset, synchronous, active-high; sampled on posedge clk
- clr  input  1  synchronous flush; empties the slice, active-high
- in_valid  input  1  upstream word offered
- in_ready  output  1  slice can accept; registered
- in_data  input  N  upstream word
- out_valid  output  1  downstream word offered; registered
- out_ready  input  1  downstream accepts
- out_data  output  N  downstream word; registered
- count  output  2  words held (0..2); registered

## Operation
- Storage: main register (drives out_data) and skid register; state EMPTY / BUSY / FULL.
- Handshakes: accept = in_valid & in_ready; send = out_valid & out_ready. in_valid/in_data must hold until accepted; out_valid/out_data hold until sent.
- State transitions, evaluated at posedge:
  - EMPTY: accept → load main, go BUSY; otherwise stay.
  - BUSY: accept & send → load main from in_data, stay; accept & !send → load skid, go FULL; !accept & send → go EMPTY; neither → stay.
  - FULL: send → main ← skid, go BUSY; otherwise stay. in_ready = 0, so no accept is possible.
- Registered outputs, derived from the next state:
  - out_valid = (state ≠ EMPTY); in_ready = (state ≠ FULL); count = 0/1/2 for EMPTY/BUSY/FULL.
- Ordering: strict FIFO. The skid word always leaves after the main word.
- clr:
  - Next state is EMPTY regardless of handshakes: out_valid = 0, in_ready = 1, count = 0 next cycle.
  - A word accepted in the clr cycle is discarded; upstream treats it as consumed.
  - A send in the clr cycle completes normally from the downstream view.
  - Data registers are left unchanged.
- rst takes priority over clr.

## Timing
- Reset values while rst is high: state EMPTY, out_valid = 0, in_ready = 0, count = 0, out_data = 0, skid = 0.
- The first posedge with rst low sets in_ready = 1. The first accept is possible in the cycle after that.
- Latency: a word accepted at edge k appears on out_data with out_valid = 1 after edge k (one cycle) when the slice is EMPTY or BUSY-with-send.
- Throughput: one word per cycle with continuous in_valid and out_ready.
- Backpressure: out_ready low for one cycle while BUSY with accept → FULL, in_ready low from the next cycle. One further word is absorbed, with no loss.
- in_ready never depends combinationally on out_ready, and out_valid never depends combinationally on in_valid. All outputs come directly from flops.
- Reset mid-operation: all held words are lost and outputs take their reset values at that edge.

## Test plan
- Reset → out_valid = 0, in_ready = 0, count = 0, out_data = 0 during rst. in_ready = 1 one cycle after rst falls.
- Stream 0x1..0x8 with in_valid and out_ready constantly high → out_data 0x1..0x8 on consecutive cycles, each one cycle after its accept; count stays 1; no bubbles.
- Send 0xA then 0xB with out_ready low → count reaches 2 and in_ready = 0. Then raise out_ready → 0xA then 0xB emitted in order, in_ready back to 1 after the first send.
- Random in_valid and out_ready (50%), 1000 words of incrementing data → output sequence equals input sequence. No word is sent while out_valid = 0, and no accept occurs while in_ready = 0.
- FULL (0x11, 0x22), then clr with out_ready high → 0x11 sent in that cycle, 0x22 dropped. Next cycle out_valid = 0, count = 0, in_ready = 1.
- rst and clr asserted together while BUSY → reset values, with in_ready = 0. rst mid-stream while FULL → out_valid = 0 at the next edge and no stale word appears after release.
